seg_scan_serial: RTL and testbench
==================================

// Module: seg_scan_serial
// PURPOSE
//  Parametrised multiplexed 7-segment display driver: for each of NUM_DIGITS digits
//  it decodes a 4-bit value, shifts the 8-bit active-low pattern MSB-first into an
//  external shift register, then enables that digit for a programmable hold time.
//  Sits between the counter/datapath logic and the board's serial LED driver pins.
// PARAMETERS
//  NUM_DIGITS  4  digits scanned, >=2; index 0 is scanned first
//  DIV         2  clk cycles per tick (tick = internal enable), >=1
//  HOLD        16 ticks a digit stays enabled after its pattern is shifted, >=1
// PORTS
//  clk         in   1             system clock
//  rst_n       in   1             asynchronous reset, active low
//  digits      in   4*NUM_DIGITS  digit k value in digits[4k+3:4k]
//  led_rst     out  1             external shift-register clear, active low
//  seg_sdo     out  1             serial segment data, valid while seg_sclk rises
//  seg_sclk    out  1             serial shift clock, toggles in SHIFT only
//  dig_sel     out  NUM_DIGITS    one-hot digit enable, all-zero while shifting
//  frame_done  out  1             1-clk pulse when the last digit finishes BLANK
// BEHAVIOUR
//  Reset: led_rst=0, seg_sdo=0, seg_sclk=0, dig_sel=0, frame_done=0, state=LOAD,
//   index=0, bit count=0, tick counter=0. First clk edge after release: led_rst=1.
//  Tick: counter 0..DIV-1, width $clog2(DIV) (min 1); pulse when counter==DIV-1.
//   All state changes below occur only on ticks (except frame_done width, 1 clk).
//  FSM:
//   LOAD : snapshot digits[4*index+:4], decode to pattern reg; -> SHIFT next tick.
//   SHIFT: 16 ticks; even tick: seg_sclk=0, seg_sdo=pattern[7-b]; odd tick:
//          seg_sclk=1, b++. After b reaches 8 -> LATCH (seg_sclk driven 0).
//   LATCH: dig_sel = 1<<index for HOLD ticks; seg_sclk=0, seg_sdo holds last bit.
//   BLANK: 1 tick, dig_sel=0; index = (index==NUM_DIGITS-1) ? 0 : index+1;
//          frame_done pulses 1 clk when index wraps; -> LOAD.
//  Digit per LOAD latency: 1+16+HOLD+1 ticks; frame = NUM_DIGITS times that.
//  Changes on digits mid-digit have no effect until that digit's next LOAD.
//  dig_sel is never non-zero while seg_sclk toggles (no ghosting).
//  Decode (bit7=dp, bits6..0 = g..a, 0 = lit): 0=C0 1=F9 2=A4 3=B0 4=99
//   5=92 6=82 7=F8 8=80 9=90; dp always off (bit7=1).
//  rst_n low mid-scan: all outputs to reset values immediately (async), scan
//   restarts at digit 0 with a fresh LOAD.
// CONFIGURATION
//  SEG_SCAN_HEX_EN defined: values A..F decode to A=88 b=83 C=C6 d=A1 E=86 F=8E.
//  Undefined: values A..F decode to FF (digit blank, shift/hold timing unchanged).
// STRUCTURE
//  Shared package seg_pkg: seg_pat_t (8-bit), SEG_BLANK=8'hFF, the 16 decode
//   constants, state enum {LOAD, SHIFT, LATCH, BLANK}.
//  Sub-module seg_decode (combinational, 4-bit in -> seg_pat_t out), holds the
//   SEG_SCAN_HEX_EN switch; reused by other display blocks.
//  Top: tick divider, FSM, bit/hold/index counters, output registers.
// TESTING
//  1 Defaults, digits=16'h4321 -> serial bytes F9,A4,B0,99 on sdo (sampled on
//    sclk rise), dig_sel 0001,0010,0100,1000 in order, frame_done once per 4.
//  2 DIV=1, HOLD=1 -> digit period exactly 19 clk; DIV=3 -> 57 clk.
//  3 digits=16'h00AF, macro off -> digits 0,1 send FF, both A and F blank;
//    macro on -> 8E then 88.
//  4 Change digits mid-SHIFT of digit 2 -> byte for digit 2 unchanged; new value
//    appears on the next frame.
//  5 Assert rst_n mid-LATCH of digit 2 -> dig_sel=0, led_rst=0 same cycle;
//    after release first byte shifted is digit 0.
//  6 Assertion throughout: dig_sel!=0 implies seg_sclk stable 0; $onehot0(dig_sel).

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display blocks.
//   seg_pat_t   : 8-bit active-low segment pattern, bit7 = dp, bits6..0 = g..a
//   SEG_BLANK   : all segments off
//   SEG_0..SEG_F: decode constants for the sixteen nibble values
//   seg_state_t : scan FSM states {LOAD, SHIFT, LATCH, BLANK}
package seg_pkg;

    typedef logic [7:0] seg_pat_t;

    localparam seg_pat_t SEG_BLANK = 8'hFF;

    localparam seg_pat_t SEG_0 = 8'hC0;
    localparam seg_pat_t SEG_1 = 8'hF9;
    localparam seg_pat_t SEG_2 = 8'hA4;
    localparam seg_pat_t SEG_3 = 8'hB0;
    localparam seg_pat_t SEG_4 = 8'h99;
    localparam seg_pat_t SEG_5 = 8'h92;
    localparam seg_pat_t SEG_6 = 8'h82;
    localparam seg_pat_t SEG_7 = 8'hF8;
    localparam seg_pat_t SEG_8 = 8'h80;
    localparam seg_pat_t SEG_9 = 8'h90;
    localparam seg_pat_t SEG_A = 8'h88;
    localparam seg_pat_t SEG_B = 8'h83;
    localparam seg_pat_t SEG_C = 8'hC6;
    localparam seg_pat_t SEG_D = 8'hA1;
    localparam seg_pat_t SEG_E = 8'h86;
    localparam seg_pat_t SEG_F = 8'h8E;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        BLANK = 2'd3
    } seg_state_t;

endpackage

// File: rtl/seg_decode.sv
// Combinational nibble to 7-segment pattern decoder (active-low, dp off).
//   value   : 4-bit digit value
//   pattern : seg_pat_t segment pattern
// Build option SEG_SCAN_HEX_EN: when defined, values A..F show hex glyphs
// (A b C d E F); otherwise they decode to a blank digit.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] value,
    output seg_pat_t   pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        case (value)
            4'h0: pattern = SEG_0;
            4'h1: pattern = SEG_1;
            4'h2: pattern = SEG_2;
            4'h3: pattern = SEG_3;
            4'h4: pattern = SEG_4;
            4'h5: pattern = SEG_5;
            4'h6: pattern = SEG_6;
            4'h7: pattern = SEG_7;
            4'h8: pattern = SEG_8;
            4'h9: pattern = SEG_9;
`ifdef SEG_SCAN_HEX_EN
            4'hA: pattern = SEG_A;
            4'hB: pattern = SEG_B;
            4'hC: pattern = SEG_C;
            4'hD: pattern = SEG_D;
            4'hE: pattern = SEG_E;
            4'hF: pattern = SEG_F;
`else
            default: pattern = SEG_BLANK;
`endif
        endcase
    end

endmodule

// File: rtl/seg_scan_serial.sv
// Multiplexed 7-segment display driver with a serial segment interface.
// For each digit in turn: decode the nibble, shift the 8-bit pattern MSB
// first into an external shift register, enable that digit for HOLD ticks,
// then blank for one tick. Index 0 is scanned first.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   digits      : digit k value in digits[4k+3:4k]
//   led_rst     : external shift-register clear, active low
//   seg_sdo     : serial segment data, stable while seg_sclk rises
//   seg_sclk    : serial shift clock, toggles only in SHIFT
//   dig_sel     : one-hot digit enable, zero whenever seg_sclk toggles
//   frame_done  : 1-clk pulse when the last digit finishes BLANK
//   state       : current FSM state, for observation
// Build option SEG_SCAN_HEX_EN is handled inside seg_decode.
module seg_scan_serial
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 2,
    parameter int HOLD       = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    output logic                    led_rst,
    output logic                    seg_sdo,
    output logic                    seg_sclk,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done,
    output seg_state_t              state
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int HW = $clog2(HOLD + 1);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic [IW-1:0] index;
    logic [2:0]    bit_cnt;
    logic          phase;     // 0: present data bit, 1: raise sclk
    logic [HW-1:0] hold_cnt;
    seg_pat_t      pattern;
    seg_pat_t      dec_pat;
    logic [3:0]    nib;

    assign tick = (tick_cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Select the nibble of the digit currently being loaded.
    always_comb begin
        nib = digits[3:0];
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (index == IW'(k)) begin
                nib = digits[4*k +: 4];
            end
        end
    end

    seg_decode u_decode (
        .value   (nib),
        .pattern (dec_pat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_rst    <= 1'b0;
            seg_sdo    <= 1'b0;
            seg_sclk   <= 1'b0;
            dig_sel    <= '0;
            frame_done <= 1'b0;
            state      <= LOAD;
            index      <= '0;
            bit_cnt    <= '0;
            phase      <= 1'b0;
            hold_cnt   <= '0;
            pattern    <= SEG_BLANK;
        end else begin
            led_rst    <= 1'b1;
            frame_done <= 1'b0;
            if (tick) begin
                case (state)
                    LOAD: begin
                        // Snapshot: later changes on digits wait for the next LOAD.
                        pattern <= dec_pat;
                        bit_cnt <= '0;
                        phase   <= 1'b0;
                        state   <= SHIFT;
                    end
                    SHIFT: begin
                        if (!phase) begin
                            seg_sclk <= 1'b0;
                            seg_sdo  <= pattern[3'd7 - bit_cnt];
                            phase    <= 1'b1;
                        end else begin
                            seg_sclk <= 1'b1;
                            bit_cnt  <= bit_cnt + 1'b1;
                            phase    <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                hold_cnt <= '0;
                                state    <= LATCH;
                            end
                        end
                    end
                    LATCH: begin
                        // sclk drops on the same edge the digit enables.
                        seg_sclk <= 1'b0;
                        dig_sel  <= SEL_ONE << index;
                        if (hold_cnt == HW'(HOLD - 1)) begin
                            state <= BLANK;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    BLANK: begin
                        dig_sel  <= '0;
                        hold_cnt <= '0;
                        if (index == IW'(NUM_DIGITS - 1)) begin
                            index      <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            index <= index + 1'b1;
                        end
                        state <= LOAD;
                    end
                    default: state <= LOAD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_serial.sv
// Bench for seg_scan_serial: main instance at default parameters checked by a
// byte/digit-select scoreboard, plus two fast instances used for period checks.
module tb_seg_scan_serial;
    import seg_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits;

    always #5 clk = ~clk;

    logic       led_rst, seg_sdo, seg_sclk, frame_done;
    logic [3:0] dig_sel;
    seg_state_t state;

    logic       led_rst2, seg_sdo2, seg_sclk2, frame_done2;
    logic [3:0] dig_sel2;
    seg_state_t state2;

    logic       led_rst3, seg_sdo3, seg_sclk3, frame_done3;
    logic [3:0] dig_sel3;
    seg_state_t state3;

    seg_scan_serial dut (
        .clk(clk), .rst_n(rst_n), .digits(digits), .led_rst(led_rst),
        .seg_sdo(seg_sdo), .seg_sclk(seg_sclk), .dig_sel(dig_sel),
        .frame_done(frame_done), .state(state)
    );

    seg_scan_serial #(.NUM_DIGITS(4), .DIV(1), .HOLD(1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .digits(digits), .led_rst(led_rst2),
        .seg_sdo(seg_sdo2), .seg_sclk(seg_sclk2), .dig_sel(dig_sel2),
        .frame_done(frame_done2), .state(state2)
    );

    seg_scan_serial #(.NUM_DIGITS(4), .DIV(3), .HOLD(1)) dut_div3 (
        .clk(clk), .rst_n(rst_n), .digits(digits), .led_rst(led_rst3),
        .seg_sdo(seg_sdo3), .seg_sclk(seg_sclk3), .dig_sel(dig_sel3),
        .frame_done(frame_done3), .state(state3)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [3:0] exp_sel_q[$];
    int frames = 0;
    int digits_in_frame = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic       prev_sclk = 1'b0;
    logic [3:0] prev_sel  = 4'b0;
    logic [7:0] shreg     = 8'h00;
    int         nbits     = 0;

    // Monitor: rebuild bytes on sclk rise, compare digit enables and frame pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            nbits           = 0;
            prev_sclk       = 1'b0;
            prev_sel        = 4'b0;
            digits_in_frame = 0;
        end else begin
            if (seg_sclk && !prev_sclk) begin
                shreg = {shreg[6:0], seg_sdo};
                nbits++;
                if (nbits == 8) begin
                    nbits = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL byte_unexpected: got %h expected none", shreg);
                    end else begin
                        check("serial_byte", 32'(shreg), 32'(exp_q.pop_front()));
                    end
                end
            end
            if (dig_sel != 4'b0 && prev_sel == 4'b0) begin
                digits_in_frame++;
                if (exp_sel_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dig_sel_unexpected: got %b expected none", dig_sel);
                end else begin
                    check("dig_sel", 32'(dig_sel), 32'(exp_sel_q.pop_front()));
                end
            end
            if (frame_done) begin
                frames++;
                check("digits_per_frame", 32'(digits_in_frame), 32'd4);
                digits_in_frame = 0;
            end
            // No ghosting: an enabled digit never sees sclk high, enables one-hot.
            if (dig_sel != 4'b0) check("no_ghost_sclk", 32'(seg_sclk), 32'd0);
            check("onehot0_dig_sel", 32'($onehot0(dig_sel)), 32'd1);
            prev_sclk = seg_sclk;
            prev_sel  = dig_sel;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
        exp_sel_q.push_back(4'b0001);
        exp_sel_q.push_back(4'b0010);
        exp_sel_q.push_back(4'b0100);
        exp_sel_q.push_back(4'b1000);
    endtask

    task automatic hold_reset(input logic [15:0] d);
        rst_n  = 1'b0;
        digits = d;
        exp_q.delete();
        exp_sel_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_frames(input int n, input string name);
        int target;
        int k;
        target = frames + n;
        k = 0;
        while (frames < target && k < n * 1000) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(frames >= target), 32'd1);
    endtask

    task automatic wait_sel(input logic [3:0] v, input string name);
        int k;
        k = 0;
        while (dig_sel != v && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(dig_sel), 32'(v));
    endtask

    // Clocks from digit 0 enable to digit 1 enable on a fast instance.
    task automatic measure(input int which, output int cyc);
        logic [3:0] s;
        int k;
        k = 0;
        s = (which == 0) ? dig_sel2 : dig_sel3;
        while (s != 4'b0001 && k < 1000) begin
            @(negedge clk);
            k++;
            s = (which == 0) ? dig_sel2 : dig_sel3;
        end
        cyc = 0;
        while (s != 4'b0010 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            s = (which == 0) ? dig_sel2 : dig_sel3;
        end
    endtask

    // ---------------- stimulus ----------------
    int per_fast;
    int per_div3;
    int k;

    initial begin
        rst_n  = 1'b1;
        digits = 16'h4321;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_led_rst", 32'(led_rst), 32'd0);
        check("rst_seg_sdo", 32'(seg_sdo), 32'd0);
        check("rst_seg_sclk", 32'(seg_sclk), 32'd0);
        check("rst_dig_sel", 32'(dig_sel), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_state", 32'(state), 32'(LOAD));
        repeat (2) @(negedge clk);

        // Digits 4321: digit0=1 F9, digit1=2 A4, digit2=3 B0, digit3=4 99.
        push_frame(8'hF9, 8'hA4, 8'hB0, 8'h99);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("led_rst_release", 32'(led_rst), 32'd1);
        fork
            measure(0, per_fast);
            measure(1, per_div3);
        join
        check("period_div1_hold1", 32'(per_fast), 32'd19);
        check("period_div3_hold1", 32'(per_div3), 32'd57);
        wait_frames(1, "frame_4321");

        // Digits 00AF: digit0=F, digit1=A, digits 2,3 = 0.
        hold_reset(16'h00AF);
`ifdef SEG_SCAN_HEX_EN
        push_frame(8'h8E, 8'h88, 8'hC0, 8'hC0);
`else
        push_frame(8'hFF, 8'hFF, 8'hC0, 8'hC0);
`endif
        rst_n = 1'b1;
        wait_frames(1, "frame_00af");

        // Change digit 2 while it is shifting: only the next frame sees it.
        hold_reset(16'h4321);
        push_frame(8'hF9, 8'hA4, 8'hB0, 8'h99);
        push_frame(8'hF9, 8'hA4, 8'h90, 8'h99);
        rst_n = 1'b1;
        wait_sel(4'b0010, "reach_digit1_latch");
        wait_sel(4'b0000, "reach_digit1_blank");
        k = 0;
        while (seg_sclk != 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("digit2_shifting", 32'(seg_sclk), 32'd1);
        digits = 16'h4921;
        wait_frames(2, "frames_midshift");

        // Reset while digit 2 is latched.
        push_frame(8'hF9, 8'hA4, 8'h90, 8'h99);
        wait_sel(4'b0100, "reach_digit2_latch");
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_dig_sel", 32'(dig_sel), 32'd0);
        check("async_rst_led_rst", 32'(led_rst), 32'd0);
        check("async_rst_sclk", 32'(seg_sclk), 32'd0);
        check("bytes_pending_at_rst", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        exp_sel_q.delete();
        repeat (2) @(negedge clk);
        push_frame(8'hF9, 8'hA4, 8'h90, 8'h99);
        rst_n = 1'b1;
        wait_frames(1, "frame_after_rst");

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("exp_sel_q_drained", 32'(exp_sel_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
